// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM note dispenser: denominations,
// cassette select encoding, error codes and FSM state encoding.
package atm_pkg;

    localparam int unsigned Denom2000 = 2000;
    localparam int unsigned Denom500  = 500;
    localparam int unsigned Denom100  = 100;

    typedef enum logic [1:0] {
        Sel2000 = 2'd0,
        Sel500  = 2'd1,
        Sel100  = 2'd2,
        SelNone = 2'd3
    } cassette_sel_e;

    typedef enum logic [1:0] {
        ErrNone   = 2'b00,
        ErrAmount = 2'b01,
        ErrNotes  = 2'b10,
        ErrJam    = 2'b11
    } err_code_e;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StPlan,
        StFeed,
        StGap,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/atm_note_dispenser_if.sv
// Bundle of the dispenser's request, note-feed, refill and status signals.
// master = transaction FSM / mechanism side, slave = dispenser.
interface atm_note_dispenser_if #(
    parameter int unsigned AMT_W = 15,
    parameter int unsigned CNT_W = 10
);
    logic             disp_req;
    logic [AMT_W-1:0] amt;
    logic             note_req;
    logic [1:0]       note_sel;
    logic             note_ack;
    logic             refill;
    logic [1:0]       refill_sel;
    logic [CNT_W-1:0] refill_cnt;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] cnt_2000;
    logic [CNT_W-1:0] cnt_500;
    logic [CNT_W-1:0] cnt_100;

    modport master (
        output disp_req, amt, note_ack, refill, refill_sel, refill_cnt,
        input  note_req, note_sel, busy, done, err, err_code, cnt_2000, cnt_500, cnt_100
    );

    modport slave (
        input  disp_req, amt, note_ack, refill, refill_sel, refill_cnt,
        output note_req, note_sel, busy, done, err, err_code, cnt_2000, cnt_500, cnt_100
    );
endinterface

// File: rtl/atm_cassette_cnt.sv
// One cassette inventory counter: loads INIT on reset, saturating add for
// refills, decrement (floored at zero) for each delivered note.
module atm_cassette_cnt #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned INIT  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_add,
    input  logic [CNT_W-1:0] i_add_cnt,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W:0]   w_sum;

    // Next count: refill saturates at all-ones, decrement never wraps.
    always_comb begin
        w_sum      = {1'b0, r_cnt} + {1'b0, i_add_cnt};
        w_cnt_next = r_cnt;
        if (i_add) begin
            w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
        end else if (i_dec && (r_cnt != '0)) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end
    end

    // Count register, reloads the initial inventory on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= CNT_W'(INIT);
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/atm_note_dispenser.sv
// Cash-dispense controller: greedy 2000/500/100 plan against the cassette
// inventory, then one-note-at-a-time feed over note_req/note_ack.
// Optional feature macro: NOTE_TIMEOUT_EN (ack watchdog, raises jam error).
module atm_note_dispenser #(
    parameter int unsigned AMT_W       = 15,
    parameter int unsigned MAX_AMT     = 20000,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned INIT_2000   = 10,
    parameter int unsigned INIT_500    = 10,
    parameter int unsigned INIT_100    = 10,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst,
    atm_note_dispenser_if.slave bus
);
    import atm_pkg::*;

    localparam logic [AMT_W-1:0] MaxAmt = AMT_W'(MAX_AMT);
    localparam logic [AMT_W-1:0] D2000  = AMT_W'(Denom2000);
    localparam logic [AMT_W-1:0] D500   = AMT_W'(Denom500);
    localparam logic [AMT_W-1:0] D100   = AMT_W'(Denom100);

    state_e           r_state, w_state_next;
    logic [AMT_W-1:0] r_rem, w_rem_next;
    logic [CNT_W-1:0] r_p2000, w_p2000_next;
    logic [CNT_W-1:0] r_p500, w_p500_next;
    logic [CNT_W-1:0] r_p100, w_p100_next;
    err_code_e        r_err_code, w_err_code_next;

    logic [CNT_W-1:0] w_cnt_2000, w_cnt_500, w_cnt_100;
    cassette_sel_e    w_sel;
    logic             w_ack, w_any_plan, w_refill_ok;
    logic             w_fit_2000, w_fit_500, w_fit_100;

`ifdef NOTE_TIMEOUT_EN
    localparam int unsigned WdogW = $clog2(ACK_TIMEOUT + 1);
    logic [WdogW-1:0] r_wdog, w_wdog_next;
`endif

    // Highest denomination still owed; stays put until the ack retires it.
    assign w_sel = (r_p2000 != '0) ? Sel2000 : (r_p500 != '0) ? Sel500 : Sel100;

    assign w_ack       = (r_state == StFeed) && bus.note_ack;
    assign w_any_plan  = (r_p2000 != '0) || (r_p500 != '0) || (r_p100 != '0);
    assign w_refill_ok = (r_state == StIdle) && bus.refill;

    // A note fits only if the remainder covers it and the cassette can back it.
    assign w_fit_2000 = (r_rem >= D2000) && (r_p2000 < w_cnt_2000);
    assign w_fit_500  = (r_rem >= D500) && (r_p500 < w_cnt_500);
    assign w_fit_100  = (r_rem >= D100) && (r_p100 < w_cnt_100);

    // Next-state and datapath next values.
    always_comb begin
        w_state_next    = r_state;
        w_rem_next      = r_rem;
        w_p2000_next    = r_p2000;
        w_p500_next     = r_p500;
        w_p100_next     = r_p100;
        w_err_code_next = r_err_code;
`ifdef NOTE_TIMEOUT_EN
        w_wdog_next     = '0;
`endif
        unique case (r_state)
            StIdle: begin
                if (bus.disp_req) begin
                    w_state_next    = StCheck;
                    w_rem_next      = bus.amt;
                    w_p2000_next    = '0;
                    w_p500_next     = '0;
                    w_p100_next     = '0;
                    w_err_code_next = ErrNone;
                end
            end
            StCheck: begin
                if ((r_rem == '0) || (r_rem > MaxAmt)) begin
                    w_state_next    = StErr;
                    w_err_code_next = ErrAmount;
                end else begin
                    w_state_next = StPlan;
                end
            end
            StPlan: begin
                if (r_rem == '0) begin
                    w_state_next = StFeed;
                end else if (r_rem < D100) begin
                    w_state_next    = StErr;
                    w_err_code_next = ErrAmount;
                end else if (w_fit_2000) begin
                    w_p2000_next = r_p2000 + CNT_W'(1);
                    w_rem_next   = r_rem - D2000;
                end else if (w_fit_500) begin
                    w_p500_next = r_p500 + CNT_W'(1);
                    w_rem_next  = r_rem - D500;
                end else if (w_fit_100) begin
                    w_p100_next = r_p100 + CNT_W'(1);
                    w_rem_next  = r_rem - D100;
                end else begin
                    w_state_next    = StErr;
                    w_err_code_next = ErrNotes;
                end
            end
            StFeed: begin
                if (bus.note_ack) begin
                    w_state_next = StGap;
                    if (w_sel == Sel2000) begin
                        w_p2000_next = r_p2000 - CNT_W'(1);
                    end else if (w_sel == Sel500) begin
                        w_p500_next = r_p500 - CNT_W'(1);
                    end else begin
                        w_p100_next = r_p100 - CNT_W'(1);
                    end
                end
`ifdef NOTE_TIMEOUT_EN
                else if (r_wdog == WdogW'(ACK_TIMEOUT - 1)) begin
                    // Unfed notes stay in the cassettes; drop the rest of the plan.
                    w_state_next    = StErr;
                    w_err_code_next = ErrJam;
                    w_p2000_next    = '0;
                    w_p500_next     = '0;
                    w_p100_next     = '0;
                end else begin
                    w_wdog_next = r_wdog + WdogW'(1);
                end
`endif
            end
            StGap: begin
                w_state_next = w_any_plan ? StFeed : StDone;
            end
            StDone, StErr: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_rem      <= '0;
            r_p2000    <= '0;
            r_p500     <= '0;
            r_p100     <= '0;
            r_err_code <= ErrNone;
`ifdef NOTE_TIMEOUT_EN
            r_wdog     <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_rem      <= w_rem_next;
            r_p2000    <= w_p2000_next;
            r_p500     <= w_p500_next;
            r_p100     <= w_p100_next;
            r_err_code <= w_err_code_next;
`ifdef NOTE_TIMEOUT_EN
            r_wdog     <= w_wdog_next;
`endif
        end
    end

    atm_cassette_cnt #(
        .CNT_W (CNT_W),
        .INIT  (INIT_2000)
    ) u_cnt_2000 (
        .clk       (clk),
        .rst       (rst),
        .i_add     (w_refill_ok && (bus.refill_sel == Sel2000)),
        .i_add_cnt (bus.refill_cnt),
        .i_dec     (w_ack && (w_sel == Sel2000)),
        .o_cnt     (w_cnt_2000)
    );

    atm_cassette_cnt #(
        .CNT_W (CNT_W),
        .INIT  (INIT_500)
    ) u_cnt_500 (
        .clk       (clk),
        .rst       (rst),
        .i_add     (w_refill_ok && (bus.refill_sel == Sel500)),
        .i_add_cnt (bus.refill_cnt),
        .i_dec     (w_ack && (w_sel == Sel500)),
        .o_cnt     (w_cnt_500)
    );

    atm_cassette_cnt #(
        .CNT_W (CNT_W),
        .INIT  (INIT_100)
    ) u_cnt_100 (
        .clk       (clk),
        .rst       (rst),
        .i_add     (w_refill_ok && (bus.refill_sel == Sel100)),
        .i_add_cnt (bus.refill_cnt),
        .i_dec     (w_ack && (w_sel == Sel100)),
        .o_cnt     (w_cnt_100)
    );

    assign bus.busy     = (r_state != StIdle);
    assign bus.done     = (r_state == StDone);
    assign bus.err      = (r_state == StErr);
    assign bus.note_req = (r_state == StFeed);
    assign bus.note_sel = (r_state == StFeed) ? w_sel : Sel2000;
    assign bus.err_code = r_err_code;
    assign bus.cnt_2000 = w_cnt_2000;
    assign bus.cnt_500  = w_cnt_500;
    assign bus.cnt_100  = w_cnt_100;
endmodule

// File: tb/tb_atm_note_dispenser.sv
// Directed bench for atm_note_dispenser. Build with +define+NOTE_TIMEOUT_EN to
// exercise the ack watchdog instead of the indefinite-wait behaviour.
module tb_atm_note_dispenser;

    logic clk = 1'b0;
    logic rst = 1'b0;

    atm_note_dispenser_if #(.AMT_W(15), .CNT_W(10)) bus ();

    atm_note_dispenser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    int unsigned sel_q[$];
    bit          txn_done;
    bit          txn_err;
    int unsigned code_at_accept;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Checks the recorded feed order: n0 x sel0, then n1 x sel1, then n2 x sel2.
    task automatic check_seq(input string tag, input int unsigned n0, input int unsigned n1,
                             input int unsigned n2);
        int unsigned bad = 0;
        int unsigned want;
        check_eq({tag, "_len"}, sel_q.size(), n0 + n1 + n2);
        for (int i = 0; i < sel_q.size(); i++) begin
            want = (i < n0) ? 0 : (i < n0 + n1) ? 1 : 2;
            if (sel_q[i] != want) bad++;
        end
        check_eq({tag, "_order"}, bad, 0);
    endtask

    task automatic check_inv(input string tag, input int unsigned c2000, input int unsigned c500,
                             input int unsigned c100);
        check_eq({tag, "_cnt2000"}, bus.cnt_2000, c2000);
        check_eq({tag, "_cnt500"}, bus.cnt_500, c500);
        check_eq({tag, "_cnt100"}, bus.cnt_100, c100);
    endtask

    task automatic do_refill(input logic [1:0] sel, input int unsigned cnt);
        bus.refill     = 1'b1;
        bus.refill_sel = sel;
        bus.refill_cnt = 10'(cnt);
        @(posedge clk); #1;
        bus.refill = 1'b0;
    endtask

    // Issues one request and services the feed. Acks the first ack_limit notes,
    // returns on done/err (after the return to IDLE) or after max_cycles.
    task automatic run_txn(input int unsigned amt, input int unsigned ack_limit,
                           input int unsigned max_cycles, input bit hold_req,
                           input bit feed_refill, input bit acc_refill,
                           input logic [1:0] rsel, input int unsigned rcnt);
        int unsigned acks = 0;
        bit          prev_req = 1'b0;
        sel_q.delete();
        txn_done = 1'b0;
        txn_err  = 1'b0;
        bus.disp_req = 1'b1;
        bus.amt      = 15'(amt);
        if (acc_refill) begin
            bus.refill     = 1'b1;
            bus.refill_sel = rsel;
            bus.refill_cnt = 10'(rcnt);
        end
        @(posedge clk); #1;
        bus.refill = 1'b0;
        if (hold_req) bus.amt = 15'd300;
        else bus.disp_req = 1'b0;
        code_at_accept = bus.err_code;
        for (int c = 0; c < max_cycles; c++) begin
            bus.note_ack = 1'b0;
            bus.refill   = 1'b0;
            if (bus.done) begin
                txn_done = 1'b1;
                break;
            end
            if (bus.err) begin
                txn_err = 1'b1;
                break;
            end
            if (bus.note_req && !prev_req) begin
                sel_q.push_back(bus.note_sel);
                if (feed_refill) begin
                    bus.refill     = 1'b1;
                    bus.refill_sel = rsel;
                    bus.refill_cnt = 10'(rcnt);
                end
                if (acks < ack_limit) begin
                    bus.note_ack = 1'b1;
                    acks++;
                end
            end
            prev_req = bus.note_req;
            @(posedge clk); #1;
        end
        bus.note_ack = 1'b0;
        bus.disp_req = 1'b0;
        bus.refill   = 1'b0;
        if (txn_done || txn_err) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.disp_req   = 1'b0;
        bus.amt        = '0;
        bus.note_ack   = 1'b0;
        bus.refill     = 1'b0;
        bus.refill_sel = 2'd0;
        bus.refill_cnt = '0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_note_req", bus.note_req, 0);
        check_eq("rst_note_sel", bus.note_sel, 0);
        check_eq("rst_err_code", bus.err_code, 0);
        check_inv("rst", 10, 10, 10);
        rst = 1'b1;
        @(posedge clk); #1;

        // 15000 from 10/10/10: 7 x 2000 then 2 x 500
        run_txn(15000, 99, 200, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_eq("t15000_done", txn_done, 1);
        check_eq("t15000_err", txn_err, 0);
        check_seq("t15000", 7, 2, 0);
        check_inv("t15000", 3, 8, 10);
        check_eq("t15000_code", bus.err_code, 0);
        check_eq("t15000_idle_busy", bus.busy, 0);

        // 15000 from 3/8/10: plan runs dry with 4000 left
        run_txn(15000, 99, 200, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_eq("short_err", txn_err, 1);
        check_eq("short_code", bus.err_code, 2);
        check_seq("short", 0, 0, 0);
        check_inv("short", 3, 8, 10);

        // Invalid amounts
        run_txn(20001, 99, 50, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_eq("big_err", txn_err, 1);
        check_eq("big_code", bus.err_code, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("code_held", bus.err_code, 1);
        run_txn(150, 99, 50, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_eq("odd_code_cleared", code_at_accept, 0);
        check_eq("odd_err", txn_err, 1);
        check_eq("odd_code", bus.err_code, 1);
        check_seq("odd", 0, 0, 0);
        run_txn(0, 99, 50, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_eq("zero_err", txn_err, 1);
        check_eq("zero_code", bus.err_code, 1);
        check_inv("invalid", 3, 8, 10);

        // Refill: plain add, saturation, sel=3 ignored
        do_refill(2'd2, 90);
        check_eq("refill_add", bus.cnt_100, 100);
        do_refill(2'd2, 1000);
        check_eq("refill_sat", bus.cnt_100, 1023);
        do_refill(2'd3, 5);
        check_inv("refill_sel3", 3, 8, 1023);

        // Refill with request in the same cycle: plan sees 5 x 2000
        run_txn(10000, 99, 100, 1'b0, 1'b0, 1'b1, 2'd0, 2);
        check_eq("refacc_done", txn_done, 1);
        check_seq("refacc", 5, 0, 0);
        check_inv("refacc", 0, 8, 1023);

        // Request held high and refill pulsed during FEED: both ignored
        run_txn(1500, 99, 100, 1'b1, 1'b1, 1'b0, 2'd1, 50);
        check_eq("busyin_done", txn_done, 1);
        check_seq("busyin", 0, 3, 0);
        check_inv("busyin", 0, 5, 1023);
        check_eq("busyin_idle", bus.busy, 0);

        // Ack outside FEED is ignored
        do_refill(2'd0, 10);
        check_eq("refill_2000", bus.cnt_2000, 10);
        bus.note_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.note_ack = 1'b0;
        check_inv("idle_ack", 10, 5, 1023);

        // 4000: ack first note, then withhold ack
        run_txn(4000, 1, 40, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_seq("stall", 2, 0, 0);
`ifdef NOTE_TIMEOUT_EN
        check_eq("jam_err", txn_err, 1);
        check_eq("jam_code", bus.err_code, 3);
        check_inv("jam", 9, 5, 1023);
        run_txn(2000, 99, 50, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_eq("afterjam_done", txn_done, 1);
        check_seq("afterjam", 1, 0, 0);
        check_eq("afterjam_cnt2000", bus.cnt_2000, 8);
`else
        check_eq("wait_no_err", txn_err, 0);
        check_eq("wait_note_req", bus.note_req, 1);
        check_eq("wait_busy", bus.busy, 1);
        check_eq("wait_code", bus.err_code, 0);
        bus.note_ack = 1'b1;
        @(posedge clk); #1;
        bus.note_ack = 1'b0;
        txn_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.done) begin
                txn_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_eq("wait_done", txn_done, 1);
        @(posedge clk); #1;
        check_inv("wait", 8, 5, 1023);
        run_txn(2000, 99, 50, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_eq("afterwait_done", txn_done, 1);
        check_seq("afterwait", 1, 0, 0);
        check_eq("afterwait_cnt2000", bus.cnt_2000, 7);
`endif

        // Reset during the second FEED of 6000
        run_txn(6000, 1, 12, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_eq("midfeed_req", bus.note_req, 1);
        check_eq("midfeed_notes", sel_q.size(), 2);
        rst = 1'b0;
        #1;
        check_eq("abort_note_req", bus.note_req, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_code", bus.err_code, 0);
        check_inv("abort", 10, 10, 10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_txn(2500, 99, 50, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check_eq("postrst_done", txn_done, 1);
        check_seq("postrst", 1, 1, 0);
        check_inv("postrst", 9, 9, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
